// File: rtl/key_event_queue.sv
// Keyboard event FIFO: edge-detects decoder key presses, queues non-zero ASCII codes
// in a first-word-fall-through buffer and raises an interrupt while data is pending.
module key_event_queue #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter logic [3:0]  IRQ_ID = 4'd1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_pressed,
  input  logic [7:0]        key_code,
  input  logic              pop,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [3:0]        irq_vector,
  input  logic              irq_done
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CNT1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR1  = ADDR_W'(1);

  typedef enum logic {S_IDLE, S_PEND} irq_state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;
  logic              r_key_dly;
  logic              r_ack_prev;
  irq_state_t        r_state;

  logic              w_press_evt;
  logic              w_pop_acc;
  logic              w_push_acc;
  logic              w_drop;
  logic [ADDR_W:0]   w_count_nxt;
  irq_state_t        w_state_nxt;

  assign w_press_evt = key_pressed & ~r_key_dly & (key_code != 8'h00);
  assign w_pop_acc   = pop & ~r_empty;
  // A full queue still accepts a press when the head is consumed in the same cycle.
  assign w_push_acc  = w_press_evt & (~r_full | w_pop_acc);
  assign w_drop      = w_press_evt & ~w_push_acc;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_acc && !w_pop_acc)
      w_count_nxt = r_count + LP_CNT1;
    else if (!w_push_acc && w_pop_acc)
      w_count_nxt = r_count - LP_CNT1;
  end

  always_ff @(posedge clk) begin
    if (w_push_acc)
      r_mem[r_wr_ptr] <= key_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_key_dly  <= 1'b0;
    end else begin
      r_key_dly <= key_pressed;
      if (w_push_acc)
        r_wr_ptr <= r_wr_ptr + LP_PTR1;
      if (w_pop_acc)
        r_rd_ptr <= r_rd_ptr + LP_PTR1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == LP_DEPTH);
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_overflow)
        r_overflow <= 1'b0;
    end
  end

  // Interrupt FSM; r_ack_prev enforces an idle cycle after an acknowledge before re-raising.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ack_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack_prev <= (r_state == S_PEND) & irq_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_push_acc)
          w_state_nxt = S_PEND;
        else if (!r_empty && !irq_done && !r_ack_prev)
          w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (irq_done && !w_push_acc)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd_data    = r_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty      = r_empty;
  assign full       = r_full;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign irq_vector = (r_state == S_PEND) ? IRQ_ID : 4'd0;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (DEPTH=16).
module tb_key_event_queue;

  logic       clk;
  logic       reset_n;
  logic       key_pressed;
  logic [7:0] key_code;
  logic       pop;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;
  logic [3:0] irq_vector;
  logic       irq_done;

  int n_checks = 0;
  int n_errors = 0;

  key_event_queue #(.DEPTH(16), .ADDR_W(4), .IRQ_ID(4'd1)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .pop          (pop),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .irq_vector   (irq_vector),
    .irq_done     (irq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; the press is seen at the following posedge.
  task automatic press(input logic [7:0] code, input int unsigned hold);
    key_code    = code;
    key_pressed = 1'b1;
    repeat (hold) @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_once();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic ack_once();
    irq_done = 1'b1;
    @(negedge clk);
    irq_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned waited;
    reset_n = 1'b0; key_pressed = 1'b0; key_code = 8'h00;
    pop = 1'b0; clr_overflow = 1'b0; irq_done = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_irq", irq_vector, 0);
    check("rst_rd", rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: single press held 100 cycles
    key_code = 8'h61; key_pressed = 1'b1;
    @(negedge clk);
    check("t1_count", count, 1);
    check("t1_rd", rd_data, 8'h61);
    check("t1_empty", empty, 0);
    check("t1_irq", irq_vector, 4'd1);
    repeat (99) @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    check("t1_held_count", count, 1);
    pop_once();
    check("t1_pop_empty", empty, 1);
    check("t1_pop_rd", rd_data, 0);
    ack_once();
    check("t1_ack_irq", irq_vector, 0);

    // 2: two presses, ordered pops, extra pop on empty
    press(8'h68, 3);
    press(8'h69, 3);
    check("t2_count", count, 2);
    check("t2_rd0", rd_data, 8'h68);
    pop_once();
    check("t2_rd1", rd_data, 8'h69);
    check("t2_count1", count, 1);
    pop_once();
    check("t2_rd2", rd_data, 8'h00);
    check("t2_empty", empty, 1);
    check("t2_count0", count, 0);
    pop_once();
    check("t2_xpop_count", count, 0);
    check("t2_xpop_empty", empty, 1);
    ack_once();

    // 3: 17 presses into 16 entries, codes 41..51
    for (int i = 0; i < 16; i++) press(8'h41 + 8'(i), 2);
    check("t3_full", full, 1);
    check("t3_count16", count, 16);
    check("t3_ovf0", overflow, 0);
    press(8'h51, 2);
    check("t3_ovf1", overflow, 1);
    check("t3_count_drop", count, 16);
    check("t3_head", rd_data, 8'h41);
    pop_once();
    check("t3_pop_rd", rd_data, 8'h42);
    check("t3_pop_full", full, 0);
    check("t3_pop_count", count, 15);
    check("t3_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("t3_ovf_clr", overflow, 0);

    // 4: press coincident with pop, full and then empty
    press(8'h70, 2);
    check("t4_refull", full, 1);
    key_code = 8'h71; key_pressed = 1'b1; pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    check("t4_full_count", count, 16);
    check("t4_full_flag", full, 1);
    check("t4_full_ovf", overflow, 0);
    check("t4_full_rd", rd_data, 8'h43);
    key_pressed = 1'b0;
    @(negedge clk);
    repeat (15) pop_once();
    check("t4_tail_rd", rd_data, 8'h71);
    check("t4_tail_count", count, 1);
    pop_once();
    check("t4_drain_empty", empty, 1);
    key_code = 8'h72; key_pressed = 1'b1; pop = 1'b1;
    @(negedge clk);
    pop = 1'b0; key_pressed = 1'b0;
    check("t4_empty_count", count, 1);
    check("t4_empty_rd", rd_data, 8'h72);
    @(negedge clk);
    pop_once();
    ack_once();
    check("t4_irq_idle", irq_vector, 0);

    // 5: ack with residual data re-raises after holdoff
    press(8'h31, 2);
    press(8'h32, 2);
    check("t5_irq_pend", irq_vector, 4'd1);
    ack_once();
    check("t5_holdoff", irq_vector, 0);
    waited = 0;
    while (irq_vector != 4'd1 && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    check("t5_reraise", irq_vector, 4'd1);
    check("t5_holdoff_len", 32'(waited >= 1), 1);
    pop_once();
    pop_once();
    check("t5_drained", empty, 1);
    ack_once();
    check("t5_ack_irq", irq_vector, 0);
    repeat (3) @(negedge clk);
    check("t5_stay_idle", irq_vector, 0);

    // 6: zero code, long hold, async reset mid-operation
    press(8'h00, 3);
    check("t6_zero_count", count, 0);
    check("t6_zero_irq", irq_vector, 0);
    press(8'h55, 1000);
    check("t6_held_count", count, 1);
    check("t6_held_rd", rd_data, 8'h55);
    press(8'h56, 2);
    press(8'h57, 2);
    check("t6_count3", count, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_irq", irq_vector, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_rd", rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_post_rst", count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
